cache_2way_ctrl: RTL and testbench
==================================

# cache_2way_ctrl

Two-way set-associative, write-through, read-allocate cache controller for the 8-bit address / 8-bit data memory system. Accepts byte read/write requests from the CPU side over a valid/ready handshake and holds 8 sets × 2 ways of one-byte lines. It drives the 256×8 RAM as its backing store. The RAM is written and read on the falling clock edge, and its read data is registered.

## Interface
- No parameters; geometry is fixed by shared package constants.
- `clk`  in  1  system clock; the controller uses the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  controller can accept; high only in IDLE.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  8  byte address; index = addr[2:0], tag = addr[7:3].
- `req_wdata`  in  8  write data.
- `resp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `resp_rdata`  out  8  read data, valid with resp_valid; 0 for writes.
- `resp_hit`  out  1  request hit, valid with resp_valid.
- `mem_w_en`, `mem_r_en`  out  1  RAM strobes.
- `mem_addr`, `mem_wdata`  out  8  RAM address and write data.
- `mem_rdata`  in  8  RAM registered read data.
- `hit_cnt`, `miss_cnt`  out  8  saturating statistics counters.

## Operation
- Request acceptance: a request is accepted on a rising edge when req_valid and req_ready are both high. Address, we and wdata are latched on that edge.
- Per-set storage: per way a valid bit, 5-bit tag and 8-bit data; one LRU bit per set, where lru = the way to replace next.
- FSM states: IDLE, LOOKUP, MEM_RD, MEM_WR.
- IDLE → LOOKUP on acceptance.
- LOOKUP, read hit: register the hit way's data into resp_rdata, pulse resp_valid with resp_hit=1, set lru=~way, go to IDLE.
- LOOKUP, read miss → MEM_RD.
- LOOKUP, write: on a hit, update the hit way's data and set lru=~way. Hit or miss, go to MEM_WR. There is no allocate on a write miss.
- MEM_RD: mem_r_en=1, mem_addr=latched address.
  - At the cycle-end edge, capture mem_rdata into resp_rdata and fill the victim way (valid=1, tag, data).
  - Set lru=~victim, pulse resp_valid with resp_hit=0, go to IDLE.
- Victim selection: way0 if invalid, else way1 if invalid, else the way named by lru.
- MEM_WR: mem_w_en=1, mem_addr/mem_wdata from the latched request. Pulse resp_valid with resp_hit equal to the LOOKUP result, go to IDLE.
- Memory strobes: decoded from the state register; mem_addr and mem_wdata are 0 outside MEM_RD/MEM_WR.
- Counters: hit_cnt or miss_cnt increments by one on each resp_valid, according to resp_hit, and saturates at 255.
- Reset: asynchronous.
  - state=IDLE; all valid=0, lru=0.
  - resp_valid=0, resp_rdata=0, resp_hit=0.
  - mem strobes, address and data = 0; both counters = 0.
  - An in-flight request is dropped with no response. RAM contents are not affected.

## Timing
- Cycle numbering: cycle 0 is the acceptance cycle; LOOKUP is cycle 1.
- Read hit: resp_valid in cycle 2.
- Read miss: MEM_RD in cycle 2. The RAM samples on the falling edge inside cycle 2 and the controller captures on the rising edge that ends it. resp_valid in cycle 3.
- Write (hit or miss): MEM_WR in cycle 2, resp_valid in cycle 3.
- req_ready is high in the same cycle as resp_valid (state is IDLE), so back-to-back requests are allowed.
- A request held while busy is not accepted until IDLE.

## Structure
- Package `cache_pkg`:
  - constants ADDR_W=8, DATA_W=8, IDX_W=3, TAG_W=5, NUM_SETS=8;
  - FSM state enum;
  - tag/index extraction helpers.
- Sub-module `cache_way_array`: one per way. Holds the valid/tag/data registers with asynchronous-reset valid bits and does the combinational tag compare. It is instantiated twice.
- Victim/LRU logic, counters and FSM live in the top module.

## Test plan
- **Cold read then hit:** after reset, read 0x2A with RAM=0.
  - First read: resp_valid in cycle 3, rdata=0x00, hit=0, miss_cnt=1.
  - Repeat read: resp in cycle 2, hit=1, hit_cnt=1.
- **Write miss, no allocate:** write 0x15←0xA5.
  - mem_w_en in cycle 2, resp hit=0.
  - Read 0x15: miss, rdata=0xA5.
  - Read 0x15 again: hit, 0xA5.
- **LRU eviction in set 3:**
  - Read 0x03, then 0x0B (fills way0, way1).
  - Read 0x03: hit, lru→way1.
  - Read 0x13: miss, evicts 0x0B.
  - Read 0x03: hit. Read 0x0B: miss.
- **Write hit:** with 0x03 cached, write 0x03←0x5C.
  - resp_hit=1, RAM[0x03]=0x5C.
  - Read 0x03: hit, 0x5C.
- **Busy hold and reset mid-fill:**
  - req_valid held high is accepted only in IDLE.
  - Assert rst during MEM_RD: mem_r_en drops immediately, no resp_valid. A subsequent read of the same address misses.
- **Counter saturation:** 300 consecutive read hits → hit_cnt=255.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared geometry, FSM encoding and address-split helpers for the 2-way cache controller.
package cache_pkg;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int IDX_W    = 3;
  localparam int TAG_W    = 5;
  localparam int NUM_SETS = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_MEM_RD,
    S_MEM_WR
  } state_e;

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return addr[IDX_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:IDX_W];
  endfunction

endpackage

// File: rtl/cache_2way_ctrl_if.sv
// CPU-side request/response channel: the CPU is master, the cache controller is slave.
interface cache_2way_ctrl_if;

  logic                        req_valid;
  logic                        req_ready;
  logic                        req_we;
  logic [cache_pkg::ADDR_W-1:0] req_addr;
  logic [cache_pkg::DATA_W-1:0] req_wdata;
  logic                        resp_valid;
  logic [cache_pkg::DATA_W-1:0] resp_rdata;
  logic                        resp_hit;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_hit
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_hit
  );

endinterface

// File: rtl/cache_way_array.sv
// One cache way: per-set valid/tag/data storage with a combinational tag compare.
module cache_way_array
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              fill_i,
  input  logic              upd_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              valid_o,
  output logic              hit_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [DATA_W-1:0]   data_q [NUM_SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_i) begin
      valid_q[idx_i] <= 1'b1;
    end
  end

  // Tag/data are only meaningful behind a set valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q[idx_i]  <= tag_i;
      data_q[idx_i] <= wdata_i;
    end else if (upd_i) begin
      data_q[idx_i] <= wdata_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign hit_o   = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
  assign rdata_o = data_q[idx_i];

endmodule

// File: rtl/cache_2way_ctrl.sv
// Two-way set-associative write-through, read-allocate cache controller with LRU and hit/miss stats.
module cache_2way_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  cache_2way_ctrl_if.slave  cpu,
  output logic              mem_w_en,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        hit_cnt,
  output logic [7:0]        miss_cnt
);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                hit_q;
  logic [NUM_SETS-1:0] lru_q;
  logic                resp_valid_q, resp_hit_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic [7:0]          hit_cnt_q, miss_cnt_q;

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic [1:0]          valid_w, hit_w, fill_w, upd_w;
  logic [DATA_W-1:0]   rdata_w0, rdata_w1, way_wdata, hit_data;
  logic                hit_any, hit_way, victim, in_rd, in_wr;

  assign idx       = addr_idx(addr_q);
  assign tag       = addr_tag(addr_q);
  assign in_rd     = (state_q == S_MEM_RD);
  assign in_wr     = (state_q == S_MEM_WR);
  assign hit_any   = |hit_w;
  assign hit_way   = hit_w[1];
  assign hit_data  = hit_way ? rdata_w1 : rdata_w0;
  assign victim    = !valid_w[0] ? 1'b0 : (!valid_w[1] ? 1'b1 : lru_q[idx]);
  assign fill_w    = {in_rd && victim, in_rd && !victim};
  assign upd_w     = (state_q == S_LOOKUP && we_q) ? hit_w : 2'b00;
  assign way_wdata = in_rd ? mem_rdata : wdata_q;

  cache_way_array u_way0 (
    .clk(clk), .rst(rst), .idx_i(idx), .tag_i(tag),
    .fill_i(fill_w[0]), .upd_i(upd_w[0]), .wdata_i(way_wdata),
    .valid_o(valid_w[0]), .hit_o(hit_w[0]), .rdata_o(rdata_w0)
  );

  cache_way_array u_way1 (
    .clk(clk), .rst(rst), .idx_i(idx), .tag_i(tag),
    .fill_i(fill_w[1]), .upd_i(upd_w[1]), .wdata_i(way_wdata),
    .valid_o(valid_w[1]), .hit_o(hit_w[1]), .rdata_o(rdata_w1)
  );

  // Request fields only matter while busy, so they are latched without reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && cpu.req_valid) begin
      addr_q  <= cpu.req_addr;
      we_q    <= cpu.req_we;
      wdata_q <= cpu.req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hit_q        <= 1'b0;
      lru_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      if (resp_valid_q) begin
        if (resp_hit_q) hit_cnt_q  <= sat_inc(hit_cnt_q);
        else            miss_cnt_q <= sat_inc(miss_cnt_q);
      end
      case (state_q)
        S_IDLE: begin
          if (cpu.req_valid) state_q <= S_LOOKUP;
        end
        S_LOOKUP: begin
          hit_q <= hit_any;
          if (hit_any) lru_q[idx] <= ~hit_way;
          if (we_q) begin
            state_q <= S_MEM_WR;
          end else if (hit_any) begin
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b1;
            resp_rdata_q <= hit_data;
            state_q      <= S_IDLE;
          end else begin
            state_q <= S_MEM_RD;
          end
        end
        S_MEM_RD: begin
          lru_q[idx]   <= ~victim;
          resp_valid_q <= 1'b1;
          resp_hit_q   <= 1'b0;
          resp_rdata_q <= mem_rdata;
          state_q      <= S_IDLE;
        end
        default: begin
          resp_valid_q <= 1'b1;
          resp_hit_q   <= hit_q;
          resp_rdata_q <= '0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu.req_ready  = (state_q == S_IDLE);
  assign cpu.resp_valid = resp_valid_q;
  assign cpu.resp_hit   = resp_hit_q;
  assign cpu.resp_rdata = resp_rdata_q;
  assign mem_r_en       = in_rd;
  assign mem_w_en       = in_wr;
  assign mem_addr       = (in_rd || in_wr) ? addr_q : '0;
  assign mem_wdata      = in_wr ? wdata_q : '0;
  assign hit_cnt        = hit_cnt_q;
  assign miss_cnt       = miss_cnt_q;

endmodule

// File: tb/tb_cache_2way_ctrl.sv
// Bench for cache_2way_ctrl: RAM model, cycle-level reference cache model and directed scenarios.
module tb_cache_2way_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mem_w_en, mem_r_en;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] hit_cnt, miss_cnt;

  cache_2way_ctrl_if cpu ();

  cache_2way_ctrl dut (
    .clk(clk), .rst(rst), .cpu(cpu),
    .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Backing RAM: written and read on the falling edge, registered read data.
  logic [7:0] ram [256] = '{default: 8'h00};
  always @(negedge clk) begin
    if (mem_w_en) ram[mem_addr] <= mem_wdata;
    if (mem_r_en) mem_rdata <= ram[mem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: cache contents, LRU, memory image and expected event cycles.
  logic       mv   [8][2];
  logic [4:0] mt   [8][2];
  logic [7:0] md   [8][2];
  logic       mlru [8];
  logic [7:0] mref [256] = '{default: 8'h00};
  int         resp_cyc = -1, rd_cyc = -1, wr_cyc = -1;
  logic [7:0] pa, pd, e_rdata;
  logic       e_hit;
  int         mhit = 0, mmiss = 0;

  task automatic model_accept(input int n);
    logic [2:0] ix;
    logic [4:0] tg;
    int         hw;
    logic       vic;
    ix = cpu.req_addr[2:0];
    tg = cpu.req_addr[7:3];
    hw = -1;
    for (int w = 0; w < 2; w++)
      if (mv[ix][w] && mt[ix][w] == tg) hw = w;
    pa = cpu.req_addr;
    pd = cpu.req_wdata;
    rd_cyc = -1;
    wr_cyc = -1;
    if (!cpu.req_we) begin
      if (hw >= 0) begin
        e_hit    = 1'b1;
        e_rdata  = md[ix][hw];
        mlru[ix] = (hw == 0);
        resp_cyc = n + 2;
      end else begin
        e_hit       = 1'b0;
        e_rdata     = mref[pa];
        vic         = !mv[ix][0] ? 1'b0 : (!mv[ix][1] ? 1'b1 : mlru[ix]);
        mv[ix][vic] = 1'b1;
        mt[ix][vic] = tg;
        md[ix][vic] = mref[pa];
        mlru[ix]    = !vic;
        rd_cyc      = n + 2;
        resp_cyc    = n + 3;
      end
    end else begin
      e_hit = (hw >= 0);
      if (hw >= 0) begin
        md[ix][hw] = pd;
        mlru[ix]   = (hw == 0);
      end
      mref[pa] = pd;
      e_rdata  = 8'h00;
      wr_cyc   = n + 2;
      resp_cyc = n + 3;
    end
  endtask

  always @(negedge clk) begin
    int  n;
    bit  idle, act;
    n = cyc;
    if (rst) begin
      chk("rst_resp_valid", cpu.resp_valid, 1'b0);
      chk("rst_resp_rdata", cpu.resp_rdata, 8'h00);
      chk("rst_resp_hit", cpu.resp_hit, 1'b0);
      chk("rst_mem_r_en", mem_r_en, 1'b0);
      chk("rst_mem_w_en", mem_w_en, 1'b0);
      chk("rst_mem_addr", mem_addr, 8'h00);
      chk("rst_mem_wdata", mem_wdata, 8'h00);
      chk("rst_hit_cnt", hit_cnt, 8'h00);
      chk("rst_miss_cnt", miss_cnt, 8'h00);
      for (int s = 0; s < 8; s++) begin
        mv[s][0] = 1'b0;
        mv[s][1] = 1'b0;
        mlru[s]  = 1'b0;
      end
      resp_cyc = -1;
      rd_cyc   = -1;
      wr_cyc   = -1;
      mhit     = 0;
      mmiss    = 0;
    end else begin
      idle = (n >= resp_cyc);
      act  = (n == rd_cyc) || (n == wr_cyc);
      chk("m_req_ready", cpu.req_ready, idle);
      chk("m_resp_valid", cpu.resp_valid, (n == resp_cyc));
      if (n == resp_cyc) begin
        chk("m_resp_rdata", cpu.resp_rdata, e_rdata);
        chk("m_resp_hit", cpu.resp_hit, e_hit);
      end
      chk("m_mem_r_en", mem_r_en, (n == rd_cyc));
      chk("m_mem_w_en", mem_w_en, (n == wr_cyc));
      chk("m_mem_addr", mem_addr, act ? pa : 8'h00);
      chk("m_mem_wdata", mem_wdata, (n == wr_cyc) ? pd : 8'h00);
      chk("m_hit_cnt", hit_cnt, mhit);
      chk("m_miss_cnt", miss_cnt, mmiss);
      if (n == resp_cyc) begin
        if (e_hit) mhit  = (mhit  == 255) ? 255 : mhit + 1;
        else       mmiss = (mmiss == 255) ? 255 : mmiss + 1;
      end
      if (cpu.req_valid && idle) model_accept(n);
    end
  end

  task automatic xact(input logic we, input logic [7:0] a, input logic [7:0] d,
                      input logic eh, input logic [7:0] ed, input int elat, input string nm);
    int t0, k;
    @(posedge clk); #1;
    cpu.req_valid = 1'b1;
    cpu.req_we    = we;
    cpu.req_addr  = a;
    cpu.req_wdata = d;
    k = 0;
    while (!cpu.req_ready && k < 20) begin @(posedge clk); #1; k++; end
    t0 = cyc;
    @(posedge clk); #1;
    cpu.req_valid = 1'b0;
    k = 0;
    while (!cpu.resp_valid && k < 10) begin @(posedge clk); #1; k++; end
    chk({nm, "_seen"}, cpu.resp_valid, 1'b1);
    chk({nm, "_lat"}, cyc - t0, elat);
    chk({nm, "_hit"}, cpu.resp_hit, eh);
    chk({nm, "_rdata"}, cpu.resp_rdata, ed);
  endtask

  initial begin
    int t0, t1, k;
    cpu.req_valid = 1'b0;
    cpu.req_we    = 1'b0;
    cpu.req_addr  = 8'h00;
    cpu.req_wdata = 8'h00;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ready", cpu.req_ready, 1'b1);
    chk("reset_hit_cnt", hit_cnt, 8'h00);

    // Cold read then hit
    xact(1'b0, 8'h2A, 8'h00, 1'b0, 8'h00, 3, "cold_rd");
    @(posedge clk); #1;
    chk("cold_miss_cnt", miss_cnt, 8'd1);
    xact(1'b0, 8'h2A, 8'h00, 1'b1, 8'h00, 2, "warm_rd");
    @(posedge clk); #1;
    chk("warm_hit_cnt", hit_cnt, 8'd1);

    // Write miss, no allocate
    xact(1'b1, 8'h15, 8'hA5, 1'b0, 8'h00, 3, "wr_miss");
    chk("wr_miss_ram", ram[8'h15], 8'hA5);
    xact(1'b0, 8'h15, 8'h00, 1'b0, 8'hA5, 3, "rd15_miss");
    xact(1'b0, 8'h15, 8'h00, 1'b1, 8'hA5, 2, "rd15_hit");

    // LRU eviction in set 3
    xact(1'b0, 8'h03, 8'h00, 1'b0, 8'h00, 3, "lru_03_fill");
    xact(1'b0, 8'h0B, 8'h00, 1'b0, 8'h00, 3, "lru_0B_fill");
    xact(1'b0, 8'h03, 8'h00, 1'b1, 8'h00, 2, "lru_03_hit");
    xact(1'b0, 8'h13, 8'h00, 1'b0, 8'h00, 3, "lru_13_evict");
    xact(1'b0, 8'h03, 8'h00, 1'b1, 8'h00, 2, "lru_03_kept");
    xact(1'b0, 8'h0B, 8'h00, 1'b0, 8'h00, 3, "lru_0B_gone");

    // Write hit updates cache and RAM
    xact(1'b1, 8'h03, 8'h5C, 1'b1, 8'h00, 3, "wr_hit");
    chk("wr_hit_ram", ram[8'h03], 8'h5C);
    xact(1'b0, 8'h03, 8'h00, 1'b1, 8'h5C, 2, "rd03_after_wr");

    // Request held high while busy is accepted only back in IDLE
    @(posedge clk); #1;
    cpu.req_valid = 1'b1;
    cpu.req_we    = 1'b0;
    cpu.req_addr  = 8'h40;
    chk("busy_first_ready", cpu.req_ready, 1'b1);
    t0 = cyc;
    @(posedge clk); #1;
    cpu.req_addr = 8'h48;
    k = 0;
    while (!cpu.req_ready && k < 10) begin @(posedge clk); #1; k++; end
    chk("busy_accept_cyc", cyc - t0, 3);
    chk("busy_first_resp", cpu.resp_valid, 1'b1);
    t1 = cyc;
    @(posedge clk); #1;
    cpu.req_valid = 1'b0;
    k = 0;
    while (!cpu.resp_valid && k < 10) begin @(posedge clk); #1; k++; end
    chk("busy_second_lat", cyc - t1, 3);
    chk("busy_second_hit", cpu.resp_hit, 1'b0);

    // Reset in the middle of a fill
    @(posedge clk); #1;
    cpu.req_valid = 1'b1;
    cpu.req_addr  = 8'h50;
    @(posedge clk); #1;
    cpu.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstfill_r_en_before", mem_r_en, 1'b1);
    rst = 1'b1;
    #1;
    chk("rstfill_r_en_after", mem_r_en, 1'b0);
    chk("rstfill_no_resp", cpu.resp_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rstfill_quiet", cpu.resp_valid, 1'b0);
    end
    xact(1'b0, 8'h50, 8'h00, 1'b0, 8'h00, 3, "rstfill_refetch");
    xact(1'b0, 8'h48, 8'h00, 1'b0, 8'h00, 3, "rstfill_48_lost");

    // Counter saturation
    for (int i = 0; i < 300; i++)
      xact(1'b0, 8'h50, 8'h00, 1'b1, 8'h00, 2, "sat_hit");
    @(posedge clk); #1;
    chk("sat_hit_cnt", hit_cnt, 8'd255);
    chk("sat_miss_cnt", miss_cnt, 8'd2);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
